aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_if.sv | 25 ++
 rtl/aes_round_ctrl.sv | 109 ++++++++++
 tb/tb_aes_round_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between an AES round controller and its
// requester, key store, datapath and consumer.
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       key_valid;
    logic       flush;
    logic       dp_load;
    logic       dp_en;
    logic [1:0] dp_mode;
    logic [3:0] round_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    modport master (
        output in_valid, key_valid, flush, out_ready,
        input  in_ready, dp_load, dp_en, dp_mode, round_idx, out_valid, busy
    );

    modport slave (
        input  in_valid, key_valid, flush, out_ready,
        output in_ready, dp_load, dp_en, dp_mode, round_idx, out_valid, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: INIT, NUM_ROUNDS-1 full rounds,
// FINAL, then hold the ciphertext in DONE until the consumer takes it.
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_round_ctrl_if.slave bus
);
    localparam int unsigned      IDX_W      = 4;
    localparam int unsigned      MODE_W     = 2;
    localparam logic [IDX_W-1:0] LAST_FULL  = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] FINAL_IDX  = IDX_W'(NUM_ROUNDS);
    localparam logic [MODE_W-1:0] MODE_ARK   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_FULL  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_FINAL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  round_idx_q, round_idx_d;
    logic              dp_en_c;
    logic [MODE_W-1:0] dp_mode_c;
    logic              abort_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            round_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
        end
    end

    // Flush only matters once a block is in flight; in IDLE it must not block acceptance.
    assign abort_c = bus.flush && (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        dp_en_c     = 1'b0;
        dp_mode_c   = MODE_ARK;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d     = S_INIT;
                    round_idx_d = '0;
                end
            end
            S_INIT: begin
                if (bus.key_valid) begin
                    dp_en_c     = 1'b1;
                    state_d     = S_ROUND;
                    round_idx_d = IDX_W'(1);
                end
            end
            S_ROUND: begin
                dp_mode_c = MODE_FULL;
                if (bus.key_valid) begin
                    dp_en_c     = 1'b1;
                    round_idx_d = round_idx_q + IDX_W'(1);
                    if (round_idx_q == LAST_FULL) begin
                        state_d     = S_FINAL;
                        round_idx_d = FINAL_IDX;
                    end
                end
            end
            S_FINAL: begin
                dp_mode_c = MODE_FINAL;
                if (bus.key_valid) begin
                    dp_en_c = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    round_idx_d = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                round_idx_d = '0;
            end
        endcase

        if (abort_c) begin
            state_d     = S_IDLE;
            round_idx_d = '0;
            dp_en_c     = 1'b0;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.dp_load   = bus.in_valid && (state_q == S_IDLE);
    assign bus.dp_en     = dp_en_c;
    assign bus.dp_mode   = dp_mode_c;
    assign bus.round_idx = round_idx_q;
    assign bus.out_valid = (state_q == S_DONE) && !bus.flush;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NUM_ROUNDS=10 and 14 instances driven in lockstep and
// compared every cycle against a key-count model of the round sequence.
module tb_aes_round_ctrl;
    localparam int unsigned NR0 = 10;
    localparam int unsigned NR1 = 14;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bit iv, kv, fl, ordy;

    aes_round_ctrl_if b0();
    aes_round_ctrl_if b1();

    assign b0.in_valid  = iv;
    assign b0.key_valid = kv;
    assign b0.flush     = fl;
    assign b0.out_ready = ordy;
    assign b1.in_valid  = iv;
    assign b1.key_valid = kv;
    assign b1.flush     = fl;
    assign b1.out_ready = ordy;

    aes_round_ctrl #(.NUM_ROUNDS(NR0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    aes_round_ctrl #(.NUM_ROUNDS(NR1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit b2b = 1'b0;

    // Model: a block in flight is described only by how many round keys it has consumed.
    bit inflight [2];
    int keys     [2];
    int stalls   [2];
    int lat_start[2];
    int last_load[2];
    int ov_cnt   [2];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int nr_of(input int k);
        return (k == 0) ? int'(NR0) : int'(NR1);
    endfunction

    task automatic check_inst(input int k, input logic ir, input logic ld, input logic en,
                              input logic [1:0] md, input logic [3:0] ix,
                              input logic ov, input logic bz);
        int    n      = nr_of(k);
        bit    active = inflight[k] && (keys[k] <= n);
        int    em     = !active ? 0 : (keys[k] == 0) ? 0 : (keys[k] < n) ? 1 : 2;
        int    ei     = !inflight[k] ? 0 : (keys[k] < n) ? keys[k] : n;
        bit    eov    = inflight[k] && (keys[k] == n + 1) && !fl;
        string p      = (k == 0) ? "r10" : "r14";
        check({p, ".in_ready"},  int'(ir), int'(!inflight[k]));
        check({p, ".dp_load"},   int'(ld), int'(iv && !inflight[k]));
        check({p, ".dp_en"},     int'(en), int'(active && kv && !fl));
        check({p, ".dp_mode"},   int'(md), em);
        check({p, ".round_idx"}, int'(ix), ei);
        check({p, ".out_valid"}, int'(ov), int'(eov));
        check({p, ".busy"},      int'(bz), int'(inflight[k]));
        if (ld) begin
            if (b2b && last_load[k] >= 0) check({p, ".spacing"}, cyc - last_load[k], n + 3);
            last_load[k] = cyc;
            lat_start[k] = cyc;
            stalls[k]    = 0;
        end
        if (ov) begin
            ov_cnt[k]++;
            check({p, ".final_idx"}, int'(ix), n);
            if (lat_start[k] >= 0) begin
                check({p, ".latency"}, cyc - lat_start[k], n + 2 + stalls[k]);
                lat_start[k] = -1;
            end
        end
    endtask

    task automatic model_edge(input int k);
        int n = nr_of(k);
        if (!inflight[k]) begin
            if (iv) begin
                inflight[k] = 1'b1;
                keys[k]     = 0;
            end
        end else if (fl) begin
            inflight[k]  = 1'b0;
            lat_start[k] = -1;
        end else if (keys[k] <= n) begin
            if (kv) keys[k]++;
            else    stalls[k]++;
        end else if (ordy) begin
            inflight[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            inflight[k]  = 1'b0;
            keys[k]      = 0;
            stalls[k]    = 0;
            lat_start[k] = -1;
            last_load[k] = -1;
        end
    endtask

    // Called at posedge+1 with inputs set; checks at the falling edge, then advances.
    task automatic step();
        #4;
        check_inst(0, b0.in_ready, b0.dp_load, b0.dp_en, b0.dp_mode, b0.round_idx, b0.out_valid, b0.busy);
        check_inst(1, b1.in_ready, b1.dp_load, b1.dp_en, b1.dp_mode, b1.round_idx, b1.out_valid, b1.busy);
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check("rst.busy",      int'(b0.busy),      0);
        check("rst.out_valid", int'(b0.out_valid), 0);
        check("rst.dp_en",     int'(b0.dp_en),     0);
        check("rst.dp_mode",   int'(b0.dp_mode),   0);
        check("rst.round_idx", int'(b0.round_idx), 0);
        check("rst.r14_busy",  int'(b1.busy),      0);
        check("rst.r14_dp_en", int'(b1.dp_en),     0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    function automatic void clear_ov();
        ov_cnt[0] = 0;
        ov_cnt[1] = 0;
    endfunction

    initial begin
        int stall_left;
        bit fired;
        rst_n = 1'b0;
        iv = 1'b0; kv = 1'b1; fl = 1'b0; ordy = 1'b1;
        model_reset();
        clear_ov();
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;

        // Nominal single block, keys always available.
        iv = 1'b1; step(); iv = 1'b0;
        repeat (20) step();
        check("nominal.ov_r10", ov_cnt[0], 1);
        check("nominal.ov_r14", ov_cnt[1], 1);

        // Key stall of three cycles while round 5 is pending.
        clear_ov();
        stall_left = 3;
        iv = 1'b1; step(); iv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (b0.busy && b0.round_idx == 4'd5 && stall_left > 0) begin
                kv = 1'b0;
                stall_left--;
            end else begin
                kv = 1'b1;
            end
            step();
        end
        kv = 1'b1;
        check("stall.applied", stall_left, 0);
        check("stall.ov_r10", ov_cnt[0], 1);

        // Consumer backpressure for four cycles.
        clear_ov();
        iv = 1'b1; step(); iv = 1'b0;
        for (int i = 0; i < 25; i++) begin
            ordy = !(b0.out_valid && ov_cnt[0] < 4);
            step();
        end
        ordy = 1'b1;
        check("bp.held_r10", ov_cnt[0], 5);

        // Flush at round 7, then a fresh block runs to completion.
        clear_ov();
        iv = 1'b1; step(); iv = 1'b0;
        for (int i = 0; i < 12 && b0.round_idx != 4'd7; i++) step();
        check("flush.reach7", int'(b0.round_idx), 7);
        fl = 1'b1; step(); fl = 1'b0;
        check("flush.busy", int'(b0.busy), 0);
        check("flush.idx", int'(b0.round_idx), 0);
        repeat (3) step();
        check("flush.no_ov", ov_cnt[0] + ov_cnt[1], 0);
        iv = 1'b1; step(); iv = 1'b0;
        repeat (20) step();
        check("flush.next_r10", ov_cnt[0], 1);
        check("flush.next_r14", ov_cnt[1], 1);

        // Asynchronous reset in the middle of round 4.
        iv = 1'b1; step(); iv = 1'b0;
        for (int i = 0; i < 10 && b0.round_idx != 4'd4; i++) step();
        check("areset.reach4", int'(b0.round_idx), 4);
        async_reset_check();
        clear_ov();
        repeat (20) step();
        check("areset.no_ov", ov_cnt[0] + ov_cnt[1], 0);

        // Back-to-back blocks with everything held high.
        b2b = 1'b1;
        last_load[0] = -1;
        last_load[1] = -1;
        iv = 1'b1; kv = 1'b1; ordy = 1'b1;
        repeat (60) step();
        b2b = 1'b0;

        // Randomized traffic with occasional flush and asynchronous reset.
        fired = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            kv   = ($urandom_range(0, 4) != 0);
            ordy = ($urandom_range(0, 1) != 0);
            fl   = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 399) == 0) begin
                async_reset_check();
                fired = 1'b1;
            end
            step();
        end
        fl = 1'b0;
        if (!fired) async_reset_check();
        iv = 1'b0; kv = 1'b1; ordy = 1'b1;
        repeat (20) step();
        check("end.idle_r10", int'(b0.busy), 0);
        check("end.idle_r14", int'(b1.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
